// File: rtl/serial_sub_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_seq_pkg
//  Brief    : Shared types and constants for the bit-serial subtract sequencer
//  Revision : 1.0 - initial release
// ============================================================================
package serial_sub_seq_pkg;

    // Default operand width matches the FP exponent field.
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_seq_pkg
`default_nettype wire

// File: rtl/serial_sub_seq_full_sub.sv
`default_nettype none
// ============================================================================
//  Module   : full_sub
//  Brief    : One-bit full subtractor cell (a - b - bin)
//  Revision : 1.0 - initial release
// ============================================================================
module full_sub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    // Difference bit and borrow out of this bit position.
    always_comb begin
        o_d    = i_a ^ i_b ^ i_bin;
        o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);
    end

endmodule : full_sub
`default_nettype wire

// File: rtl/serial_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_seq
//  Brief    : Bit-serial subtractor, LSB first, one bit per clock, with
//             valid/ready handshakes on operands and result
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub_seq
    import serial_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int             CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_d_sr;
    logic               r_bc;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_d;
    logic               w_bo;
    logic               w_accept;
    logic               w_shift;

    // Single subtractor cell, fed by the LSBs of the operand shifters.
    full_sub u_full_sub (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_bc),
        .o_d    (w_d),
        .o_bout (w_bo)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // A new operand offered alongside out_ready waits for IDLE.
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // Operand load, per-bit shift, borrow carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_d_sr <= '0;
            r_bc   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_bc   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
            r_bc   <= w_bo;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers drive the outputs directly and hold the last result.
    assign diff   = r_d_sr;
    assign borrow = r_bc;

endmodule : serial_sub_seq
`default_nettype wire
